// File: rtl/tdc_tot_assembler.sv
// TOT word assembler for the TDC path.
// Combines the fine phase code and coarse count from the TOT fine encoder into
// one linear TOT word, flags encoder errors and saturation, keeps saturating
// error/drop counters, and buffers results in a 2-entry first-word-fall-through
// FIFO toward the pixel readout.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   hit_valid         one-cycle hit strobe qualifying fine_code/fine_err/coarse_cnt
//   fine_code         6-bit fine phase code
//   fine_err          bubble error flag from the fine encoder
//   coarse_cnt        TOT coarse count
//   cnt_clear         synchronous clear of err_count and drop_count
//   tot_valid/ready   valid/ready handshake of the FIFO head
//   tot_code          assembled TOT of the FIFO head
//   tot_flags         {sat, err} of the FIFO head
//   err_count         saturating count of hits with err=1
//   drop_count        saturating count of hits lost to a full FIFO
module tdc_tot_assembler #(
  parameter int unsigned FINE_STEPS = 42,
  parameter int unsigned COARSE_W   = 3,
  parameter int unsigned TOT_W      = 9,
  parameter int unsigned ERRCNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hit_valid,
  input  logic [5:0]          fine_code,
  input  logic                fine_err,
  input  logic [COARSE_W-1:0] coarse_cnt,
  input  logic                cnt_clear,
  output logic                tot_valid,
  input  logic                tot_ready,
  output logic [TOT_W-1:0]    tot_code,
  output logic [1:0]          tot_flags,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [ERRCNT_W-1:0] drop_count
);

  localparam int unsigned SumW = TOT_W + 1;
  localparam logic [SumW-1:0] TotMax = {1'b0, {TOT_W{1'b1}}};

  // Stage S1: capture and classify the hit
  logic                s1_valid_q;
  logic                s1_err_q;
  logic [5:0]          s1_fine_q;
  logic [COARSE_W-1:0] s1_coarse_q;
  logic                s1_err_d;

  assign s1_err_d = fine_err | (32'(fine_code) >= FINE_STEPS);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_fine_q   <= '0;
      s1_coarse_q <= '0;
    end else begin
      s1_valid_q <= hit_valid;
      if (hit_valid) begin
        s1_err_q    <= s1_err_d;
        s1_fine_q   <= s1_err_d ? 6'd0 : fine_code;
        s1_coarse_q <= coarse_cnt;
      end
    end
  end

  // Stage S2: linearise and saturate
  logic [SumW-1:0]  sum;
  logic             s2_sat_d;
  logic [TOT_W-1:0] s2_tot_d;
  logic             s2_valid_q;
  logic             s2_err_q;
  logic             s2_sat_q;
  logic [TOT_W-1:0] s2_tot_q;

  always_comb begin
    sum      = SumW'(s1_coarse_q) * SumW'(FINE_STEPS) + SumW'(s1_fine_q);
    s2_sat_d = (sum > TotMax);
    s2_tot_d = s2_sat_d ? {TOT_W{1'b1}} : sum[TOT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_sat_q   <= 1'b0;
      s2_tot_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_err_q <= s1_err_q;
        s2_sat_q <= s2_sat_d;
        s2_tot_q <= s2_tot_d;
      end
    end
  end

  // 2-entry FWFT FIFO
  logic [TOT_W-1:0] mem_code_q  [2];
  logic [1:0]       mem_flags_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             full, pop, push, drop;

  always_comb begin
    full    = (count_q == 2'd2);
    pop     = tot_valid & tot_ready;
    // A pop frees the slot being written, so push succeeds even when full.
    push    = s2_valid_q & (~full | pop);
    drop    = s2_valid_q & full & ~pop;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_code_q[wr_ptr_q]  <= s2_tot_q;
      mem_flags_q[wr_ptr_q] <= {s2_sat_q, s2_err_q};
    end
  end

  assign tot_valid = (count_q != 2'd0);
  assign tot_code  = tot_valid ? mem_code_q[rd_ptr_q]  : '0;
  assign tot_flags = tot_valid ? mem_flags_q[rd_ptr_q] : 2'b00;

  // Saturating counters; cnt_clear wins over a same-cycle increment
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;
  logic [ERRCNT_W-1:0] drop_count_q, drop_count_d;

  always_comb begin
    err_count_d  = err_count_q;
    drop_count_d = drop_count_q;
    if (cnt_clear) begin
      err_count_d  = '0;
      drop_count_d = '0;
    end else begin
      if (s2_valid_q && s2_err_q && (err_count_q != {ERRCNT_W{1'b1}})) begin
        err_count_d = err_count_q + 1'b1;
      end
      if (drop && (drop_count_q != {ERRCNT_W{1'b1}})) begin
        drop_count_d = drop_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      err_count_q  <= err_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign err_count  = err_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_tdc_tot_assembler.sv
// Randomised self-checking bench for tdc_tot_assembler. Two instances share the
// same stimulus: the default build and a narrow build (TOT_W=8, ERRCNT_W=2) that
// exercises output saturation and counter limits.
module tb_tdc_tot_assembler;

  localparam int unsigned FineSteps = 42;

  logic       clk = 1'b0;
  logic       reset, hit_valid, fine_err, cnt_clear, tot_ready;
  logic [5:0] fine_code;
  logic [2:0] coarse_cnt;

  logic       tot_valid_a, tot_valid_b;
  logic [8:0] tot_code_a;
  logic [7:0] tot_code_b;
  logic [1:0] tot_flags_a, tot_flags_b;
  logic [7:0] err_count_a, drop_count_a;
  logic [1:0] err_count_b, drop_count_b;

  always #5 clk = ~clk;

  tdc_tot_assembler u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .hit_valid  (hit_valid),
    .fine_code  (fine_code),
    .fine_err   (fine_err),
    .coarse_cnt (coarse_cnt),
    .cnt_clear  (cnt_clear),
    .tot_valid  (tot_valid_a),
    .tot_ready  (tot_ready),
    .tot_code   (tot_code_a),
    .tot_flags  (tot_flags_a),
    .err_count  (err_count_a),
    .drop_count (drop_count_a)
  );

  tdc_tot_assembler #(
    .TOT_W    (8),
    .ERRCNT_W (2)
  ) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .hit_valid  (hit_valid),
    .fine_code  (fine_code),
    .fine_err   (fine_err),
    .coarse_cnt (coarse_cnt),
    .cnt_clear  (cnt_clear),
    .tot_valid  (tot_valid_b),
    .tot_ready  (tot_ready),
    .tot_code   (tot_code_b),
    .tot_flags  (tot_flags_b),
    .err_count  (err_count_b),
    .drop_count (drop_count_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each hit becomes one result that reaches the FIFO two
  // edges after capture; the FIFO is a bounded queue of depth 2.
  typedef struct {
    int unsigned tot_a;
    bit          sat_a;
    int unsigned tot_b;
    bit          sat_b;
    bit          err;
  } ent_t;

  ent_t        p1, p2;
  bit          p1_v = 1'b0, p2_v = 1'b0;
  ent_t        q[$];
  int unsigned ecnt_a = 0, ecnt_b = 0, dcnt_a = 0, dcnt_b = 0;

  function automatic ent_t make_ent(input int unsigned c, input int unsigned f, input bit fe);
    ent_t        e;
    int unsigned sum;
    e.err   = fe || (f >= FineSteps);
    sum     = c * FineSteps + (e.err ? 0 : f);
    e.sat_a = (sum > 511);
    e.tot_a = e.sat_a ? 511 : sum;
    e.sat_b = (sum > 255);
    e.tot_b = e.sat_b ? 255 : sum;
    return e;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic model_edge();
    bit do_drop;
    if (reset) begin
      p1_v = 1'b0;
      p2_v = 1'b0;
      q.delete();
      ecnt_a = 0; ecnt_b = 0; dcnt_a = 0; dcnt_b = 0;
    end else begin
      do_drop = 1'b0;
      if (q.size() > 0 && tot_ready) void'(q.pop_front());
      if (p2_v) begin
        if (q.size() < 2) q.push_back(p2);
        else do_drop = 1'b1;
      end
      if (cnt_clear) begin
        ecnt_a = 0; ecnt_b = 0; dcnt_a = 0; dcnt_b = 0;
      end else begin
        if (p2_v && p2.err) begin
          ecnt_a = sat_inc(ecnt_a, 255);
          ecnt_b = sat_inc(ecnt_b, 3);
        end
        if (do_drop) begin
          dcnt_a = sat_inc(dcnt_a, 255);
          dcnt_b = sat_inc(dcnt_b, 3);
        end
      end
      p2_v = p1_v;
      p2   = p1;
      p1_v = hit_valid;
      p1   = make_ent(32'(coarse_cnt), 32'(fine_code), fine_err);
    end
  endtask

  task automatic compare_all();
    check_eq("valid_a", 32'(tot_valid_a), 32'(q.size() > 0));
    check_eq("valid_b", 32'(tot_valid_b), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check_eq("code_a", 32'(tot_code_a), q[0].tot_a);
      check_eq("flags_a", 32'(tot_flags_a), 32'({q[0].sat_a, q[0].err}));
      check_eq("code_b", 32'(tot_code_b), q[0].tot_b);
      check_eq("flags_b", 32'(tot_flags_b), 32'({q[0].sat_b, q[0].err}));
    end
    check_eq("errcnt_a", 32'(err_count_a), ecnt_a);
    check_eq("errcnt_b", 32'(err_count_b), ecnt_b);
    check_eq("dropcnt_a", 32'(drop_count_a), dcnt_a);
    check_eq("dropcnt_b", 32'(drop_count_b), dcnt_b);
  endtask

  // Drive one cycle of inputs at the falling edge, update the model on the
  // rising edge, then compare at the next falling edge.
  task automatic cycle(input bit hv, input int unsigned c, input int unsigned f, input bit fe,
                       input bit rdy, input bit clr, input bit rst);
    hit_valid  = hv;
    coarse_cnt = 3'(c);
    fine_code  = 6'(f);
    fine_err   = fe;
    tot_ready  = rdy;
    cnt_clear  = clr;
    reset      = rst;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 0, 0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; hit_valid = 1'b0; fine_code = '0; fine_err = 1'b0;
    coarse_cnt = '0; cnt_clear = 1'b0; tot_ready = 1'b0;
    @(negedge clk);

    // Reset then idle
    repeat (2) cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_code", 32'(tot_code_a), 0);
    check_eq("rst_flags", 32'(tot_flags_a), 0);
    repeat (10) idle(1'b0);

    // Single hit: head appears exactly three cycles after the strobe
    cycle(1'b1, 3, 17, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check_eq("lat_early", 32'(tot_valid_a), 0);
    idle(1'b1);
    check_eq("lat_valid", 32'(tot_valid_a), 1);
    check_eq("lat_code", 32'(tot_code_a), 143);
    idle(1'b1);

    // Bubble error and out-of-range fine code
    cycle(1'b1, 2, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 2, 45, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check_eq("bub_code", 32'(tot_code_a), 84);
    check_eq("bub_flags", 32'(tot_flags_a), 1);
    check_eq("bub_errcnt", 32'(err_count_a), 1);
    idle(1'b1);
    check_eq("oor_code", 32'(tot_code_a), 84);
    check_eq("oor_flags", 32'(tot_flags_a), 1);
    check_eq("oor_errcnt", 32'(err_count_a), 2);
    idle(1'b1);

    // Backpressure: four hits into a two-deep FIFO
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int f = 1; f <= 4; f++) cycle(1'b1, 0, f, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    check_eq("bp_drop", 32'(drop_count_a), 2);
    check_eq("bp_head", 32'(tot_code_a), 1);
    idle(1'b1);
    check_eq("bp_second", 32'(tot_code_a), 2);
    idle(1'b1);
    check_eq("bp_empty", 32'(tot_valid_a), 0);

    // Saturation in the narrow build
    cycle(1'b1, 7, 41, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) idle(1'b1);
    check_eq("sat_code_b", 32'(tot_code_b), 255);
    check_eq("sat_flags_b", 32'(tot_flags_b), 2);
    check_eq("sat_code_a", 32'(tot_code_a), 335);
    idle(1'b1);

    // Counter limit and clear priority
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (5) cycle(1'b1, 1, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) idle(1'b1);
    check_eq("lim_err_b", 32'(err_count_b), 3);
    check_eq("lim_err_a", 32'(err_count_a), 5);
    cycle(1'b1, 1, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("clr_err_a", 32'(err_count_a), 0);
    check_eq("clr_err_b", 32'(err_count_b), 0);
    idle(1'b1);

    // Reset with two entries buffered and one in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, i, 10, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("mid_rst_valid", 32'(tot_valid_a), 0);
    cycle(1'b1, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) idle(1'b1);
    check_eq("post_rst_code", 32'(tot_code_a), 42);
    idle(1'b1);
    check_eq("post_rst_alone", 32'(tot_valid_a), 0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      int unsigned f;
      f = ($urandom_range(0, 9) < 7) ? $urandom_range(0, FineSteps - 1) : $urandom_range(0, 63);
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 7), f, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 499) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
